// File: rtl/cpu_pkg.sv
// cpu_pkg: shared instruction encodings, fetch FSM states and operand-length helper
package cpu_pkg;
  localparam logic [1:0] MODE_IMM = 2'b00;
  localparam logic [1:0] MODE_DIR = 2'b01;
  localparam logic [1:0] MODE_INDIR = 2'b10;
  localparam logic [1:0] MODE_REG = 2'b11;
  localparam logic [5:0] OP_HALT = 6'h3F;
  localparam logic [5:0] OP_IMPLIED_MAX = 6'h07;
  typedef enum logic [2:0] {
    IDLE,
    FETCH_OP,
    LATCH_OP,
    FETCH_OPND,
    LATCH_OPND,
    VALID,
    HALTED
  } fetch_state_t;
  function automatic logic has_operand(input logic [5:0] op);
    return op > OP_IMPLIED_MAX;
  endfunction
endpackage

// File: rtl/instr_fetch.sv
// instr_fetch: fetches one- or two-byte instructions from synchronous RAM and presents them decoded
module instr_fetch
  import cpu_pkg::*;
#(
  parameter int RAM_ADDR_WIDTH = 8,
  parameter int RAM_DATA_WIDTH = 8,
  parameter int OPCODE_WIDTH = 6,
  parameter int MODE_WIDTH = 2,
  parameter int OPERAND_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      run,
  input  logic [RAM_DATA_WIDTH-1:0] fetch_data,
  input  logic                      branch_en,
  input  logic [RAM_ADDR_WIDTH-1:0] branch_target,
  input  logic                      instr_ready,
  output logic                      fetch_rd_en,
  output logic [RAM_ADDR_WIDTH-1:0] fetch_addr,
  output logic                      instr_valid,
  output logic [OPCODE_WIDTH-1:0]   opcode_out,
  output logic [MODE_WIDTH-1:0]     mode_out,
  output logic [OPERAND_WIDTH-1:0]  operand_out,
  output logic [RAM_ADDR_WIDTH-1:0] instr_pc,
  output logic                      halted
);
  fetch_state_t state;
  logic [RAM_ADDR_WIDTH-1:0] pc;
  logic [OPCODE_WIDTH-1:0] op;
  assign op = fetch_data[RAM_DATA_WIDTH-1 -: OPCODE_WIDTH];
  assign fetch_rd_en = state == FETCH_OP || state == FETCH_OPND;
  assign fetch_addr = fetch_rd_en ? pc : '0;
  assign instr_valid = state == VALID;
  assign halted = state == HALTED;
  // Fetch sequencer: a branch outside IDLE/HALTED abandons whatever is in flight and refetches at the target
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pc <= '0;
      instr_pc <= '0;
      opcode_out <= '0;
      mode_out <= '0;
      operand_out <= '0;
    end else if (branch_en && state != IDLE && state != HALTED) begin
      pc <= branch_target;
      state <= FETCH_OP;
    end else begin
      case (state)
        IDLE: begin
          if (branch_en) pc <= branch_target;
          if (run) state <= FETCH_OP;
        end
        FETCH_OP: state <= LATCH_OP;
        LATCH_OP: begin
          opcode_out <= op;
          mode_out <= fetch_data[MODE_WIDTH-1:0];
          operand_out <= '0;
          instr_pc <= pc;
          pc <= pc + 1'b1;
          state <= op == OPCODE_WIDTH'(OP_HALT) ? HALTED : has_operand(6'(op)) ? FETCH_OPND : VALID;
        end
        FETCH_OPND: state <= LATCH_OPND;
        LATCH_OPND: begin
          operand_out <= OPERAND_WIDTH'(fetch_data);
          pc <= pc + 1'b1;
          state <= VALID;
        end
        VALID: if (instr_ready) state <= run ? FETCH_OP : IDLE;
        HALTED: if (branch_en) pc <= branch_target;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: scoreboard bench with a RAM model and an instruction-level reference model
module tb_instr_fetch;
  logic clk = 0, rst_n = 0, run = 0, branch_en = 0, instr_ready = 0;
  logic [7:0] fetch_data = 0, branch_target = 0;
  logic fetch_rd_en, instr_valid, halted;
  logic [7:0] fetch_addr, operand_out, instr_pc;
  logic [5:0] opcode_out;
  logic [1:0] mode_out;
  logic [7:0] mem [256];
  typedef struct packed {
    logic [5:0] op;
    logic [1:0] mode;
    logic [7:0] opnd;
    logic [7:0] pc;
  } exp_t;
  exp_t sb[$];
  int checks = 0, errors = 0;

  instr_fetch dut (
    .clk(clk), .rst_n(rst_n), .run(run), .fetch_data(fetch_data),
    .branch_en(branch_en), .branch_target(branch_target), .instr_ready(instr_ready),
    .fetch_rd_en(fetch_rd_en), .fetch_addr(fetch_addr), .instr_valid(instr_valid),
    .opcode_out(opcode_out), .mode_out(mode_out), .operand_out(operand_out),
    .instr_pc(instr_pc), .halted(halted)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (fetch_rd_en) fetch_data <= mem[fetch_addr];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [5:0] op, input logic [1:0] mode, input logic [7:0] opnd, input logic [7:0] pc);
    exp_t e;
    e.op = op;
    e.mode = mode;
    e.opnd = opnd;
    e.pc = pc;
    return e;
  endfunction

  function automatic exp_t model(input logic [7:0] p);
    logic [7:0] b, nxt;
    b = mem[p];
    nxt = p + 8'd1;
    return mk(b[7:2], b[1:0], b[7:2] > 6'd7 ? mem[nxt] : 8'h00, p);
  endfunction

  function automatic logic [7:0] ilen(input logic [7:0] p);
    logic [7:0] b;
    b = mem[p];
    return b[7:2] > 6'd7 ? 8'd2 : 8'd1;
  endfunction

  initial forever begin
    exp_t e;
    @(negedge clk);
    #2;
    if (rst_n && instr_valid && instr_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_instr got pc %0h want none", instr_pc);
      end else begin
        e = sb.pop_front();
        chk("opcode", opcode_out, e.op);
        chk("mode", mode_out, e.mode);
        chk("operand", operand_out, e.opnd);
        chk("instr_pc", instr_pc, e.pc);
        chk("rd_en_in_valid", fetch_rd_en, 0);
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    #3;
    rst_n = 0;
    run = 0;
    instr_ready = 0;
    branch_en = 0;
    #1;
    chk("rst_valid", instr_valid, 0);
    chk("rst_rd_en", fetch_rd_en, 0);
    chk("rst_halted", halted, 0);
    chk("rst_addr", fetch_addr, 0);
    chk("rst_outs", {opcode_out, mode_out, operand_out, instr_pc}, 0);
    chk("sb_drained", sb.size(), 0);
    sb.delete();
    for (int i = 0; i < 256; i++) mem[i] = 8'h0C;
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic wait_fetch(output logic [7:0] addr);
    addr = 8'hxx;
    for (int i = 0; i < 20; i++) begin
      if (fetch_rd_en) begin
        addr = fetch_addr;
        return;
      end
      @(posedge clk);
      #1;
    end
    chk("fetch_timeout", 1, 0);
  endtask

  task automatic latency(output int lat);
    lat = 99;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk);
      #1;
      if (instr_valid) begin
        lat = i;
        return;
      end
    end
  endtask

  task automatic accept();
    @(negedge clk);
    instr_ready = 1;
    @(negedge clk);
    instr_ready = 0;
  endtask

  initial begin
    logic [7:0] a, mpc, b;
    int l, hs;
    do_reset();
    mem[0] = 8'h25; mem[1] = 8'h40; mem[2] = 8'h0C;
    @(negedge clk); run = 1;
    wait_fetch(a); chk("t1_addr", a, 0);
    latency(l); chk("t1_latency", l, 4);
    sb.push_back(mk(6'h09, 2'b01, 8'h40, 8'h00));
    accept();

    do_reset();
    @(negedge clk); run = 1;
    wait_fetch(a); chk("t2_addr", a, 0);
    latency(l); chk("t2_latency", l, 2);
    sb.push_back(mk(6'h03, 2'b00, 8'h00, 8'h00));
    accept();
    wait_fetch(a); chk("t2_next_addr", a, 1);

    do_reset();
    mem[0] = 8'h25; mem[1] = 8'h40;
    @(negedge clk); run = 1;
    wait_fetch(a);
    latency(l); chk("t3_latency", l, 4);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("stall_valid", instr_valid, 1);
      chk("stall_rd_en", fetch_rd_en, 0);
      chk("stall_outs", {opcode_out, mode_out, operand_out, instr_pc}, {6'h09, 2'b01, 8'h40, 8'h00});
    end
    sb.push_back(mk(6'h09, 2'b01, 8'h40, 8'h00));
    accept();
    wait_fetch(a); chk("t3_next_addr", a, 2);

    do_reset();
    mem[0] = 8'h25; mem[1] = 8'h40;
    @(negedge clk); run = 1;
    wait_fetch(a);
    @(posedge clk);
    @(negedge clk); branch_target = 8'h80; branch_en = 1;
    @(negedge clk); branch_en = 0;
    wait_fetch(a); chk("t4_branch_addr", a, 8'h80);
    latency(l); chk("t4_latency", l, 2);
    sb.push_back(mk(6'h03, 2'b00, 8'h00, 8'h80));
    accept();

    do_reset();
    mem[8'hFF] = 8'h25; mem[0] = 8'h11;
    @(negedge clk); branch_target = 8'hFF; branch_en = 1;
    @(negedge clk); branch_en = 0;
    chk("t5_idle_branch_rd_en", fetch_rd_en, 0);
    run = 1;
    wait_fetch(a); chk("t5_addr", a, 8'hFF);
    latency(l); chk("t5_latency", l, 4);
    sb.push_back(mk(6'h09, 2'b01, 8'h11, 8'hFF));
    accept();
    wait_fetch(a); chk("t5_wrap_next_addr", a, 1);

    do_reset();
    mem[0] = 8'hFC;
    @(negedge clk); run = 1;
    for (int i = 0; i < 10 && !halted; i++) @(negedge clk);
    chk("t6_halted", halted, 1);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      chk("t6_no_fetch", fetch_rd_en, 0);
      chk("t6_no_valid", instr_valid, 0);
    end

    do_reset();
    for (int i = 0; i < 256; i++) begin
      b = 8'($urandom);
      if (b[7:2] == 6'h3F) b[7] = 1'b0;
      mem[i] = b;
    end
    mpc = 0;
    hs = 0;
    for (int c = 0; c < 4000 && hs < 80; c++) begin
      @(negedge clk);
      branch_en = 0;
      run = ($urandom % 4) != 0;
      instr_ready = instr_valid ? 1'($urandom % 2) : 1'b0;
      if (instr_valid && instr_ready) begin
        sb.push_back(model(mpc));
        mpc = mpc + ilen(mpc);
        hs++;
      end
      if ($urandom % 10 == 0) begin
        branch_en = 1;
        branch_target = 8'($urandom);
        mpc = branch_target;
      end
    end
    @(negedge clk);
    run = 0; instr_ready = 0; branch_en = 0;
    repeat (10) @(negedge clk);
    chk("rand_handshakes", hs, 80);
    chk("rand_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameters SHALL be: RAM_ADDR_WIDTH, default 8, fetch address width; RAM_DATA_WIDTH, default 8, instruction byte width; OPCODE_WIDTH, default 6, opcode field width; MODE_WIDTH, default 2, addressing-mode field width; OPERAND_WIDTH, default 8, operand width.
REQ-002 Ports SHALL be, in order:
- clk, in, 1, the single clock.
- rst_n, in, 1, asynchronous active-low reset.
- run, in, 1, starts fetching from the current PC.
- fetch_data, in, RAM_DATA_WIDTH, RAM read data.
- branch_en, in, 1, one-cycle redirect request.
- branch_target, in, RAM_ADDR_WIDTH, redirect address.
- instr_ready, in, 1, downstream operand stage accepts.
- fetch_rd_en, out, 1, RAM read strobe.
- fetch_addr, out, RAM_ADDR_WIDTH, RAM read address.
- instr_valid, out, 1, decoded instruction available.
- opcode_out, out, OPCODE_WIDTH, decoded opcode.
- mode_out, out, MODE_WIDTH, decoded mode (00 IMM, 01 DIR, 10 INDIR, 11 REG).
- operand_out, out, OPERAND_WIDTH, decoded operand.
- instr_pc, out, RAM_ADDR_WIDTH, address of the instruction's first byte.
- halted, out, 1, HALT fetched.
REQ-003 The block SHALL have one clock; reset SHALL be asynchronous and active-low.

Function
REQ-004 Instruction byte0 SHALL be {opcode[7:2], mode[1:0]}.
REQ-005 Opcodes 0x00-0x07 SHALL be one-byte (implied); for these, operand_out SHALL be 0.
REQ-006 All other opcodes SHALL carry a second byte, which is the operand.
REQ-007 Opcode 0x3F SHALL be HALT.
REQ-008 RAM reads SHALL be synchronous: with fetch_rd_en=1 and fetch_addr=A in cycle N, fetch_data = mem[A] in cycle N+1.
REQ-009 The FSM SHALL have states IDLE, FETCH_OP, LATCH_OP, FETCH_OPND, LATCH_OPND, VALID and HALTED.
REQ-010 IDLE SHALL go to FETCH_OP when run=1.
REQ-011 FETCH_OP SHALL drive fetch_rd_en=1 and fetch_addr=pc, then go to LATCH_OP.
REQ-012 LATCH_OP SHALL capture opcode/mode, set instr_pc=pc and pc=pc+1.
REQ-013 From LATCH_OP: a one-byte non-HALT opcode SHALL go to VALID; HALT SHALL go to HALTED; any other opcode SHALL go to FETCH_OPND.
REQ-014 FETCH_OPND SHALL drive fetch_rd_en=1 and fetch_addr=pc, then go to LATCH_OPND.
REQ-015 LATCH_OPND SHALL capture the operand, set pc=pc+1 and go to VALID.
REQ-016 In VALID, instr_valid SHALL be 1 and opcode_out, mode_out, operand_out and instr_pc SHALL hold stable.
REQ-017 In VALID with instr_ready=1, the FSM SHALL go to FETCH_OP, or to IDLE if run=0.
REQ-018 Latency SHALL be 2 cycles from entry to FETCH_OP to instr_valid for a one-byte instruction, and 4 cycles for a two-byte instruction.
REQ-019 fetch_rd_en SHALL be 0 in every state other than FETCH_OP and FETCH_OPND.
REQ-020 The PC SHALL wrap modulo 2^RAM_ADDR_WIDTH: an opcode at 0xFF SHALL take its operand from 0x00.
REQ-021 branch_en=1 in any state except IDLE and HALTED SHALL set pc=branch_target, abandon any partial instruction, drop instr_valid the next cycle and go to FETCH_OP.
REQ-022 If branch_en=1 coincides with a VALID/instr_ready handshake, the handshake SHALL complete and the branch SHALL redirect the next fetch.
REQ-023 branch_en in IDLE or HALTED SHALL only load pc, without changing state.
REQ-024 HALTED SHALL assert halted=1, keep instr_valid=0 and be left only by reset.
REQ-025 A run deassertion SHALL take effect only at an instruction boundary (VALID handshake); a partially fetched instruction SHALL complete.

Reset
REQ-026 While rst_n=0, the state SHALL be IDLE and pc, instr_pc, opcode_out, mode_out and operand_out SHALL be 0.
REQ-027 While rst_n=0, instr_valid, fetch_rd_en and halted SHALL be 0 and fetch_addr SHALL be 0.
REQ-028 Reset asserted mid-fetch SHALL discard the partial instruction immediately (asynchronously).
REQ-029 After reset release, the FSM SHALL remain in IDLE until run=1.

Structure
REQ-030 A shared package cpu_pkg SHALL hold the mode encodings (IMM/DIR/INDIR/REG), the HALT opcode constant, the implied-opcode limit and the fetch FSM state enum.
REQ-031 The block SHALL be a single module with no sub-modules; the operand-length decision SHALL be a function in cpu_pkg (has_operand).

Verification
REQ-032 mem[0]=0x25 (opcode 0x09, DIR), mem[1]=0x40, run=1, instr_ready=1 -> instr_valid high 4 cycles after FETCH_OP with opcode_out=0x09, mode_out=01, operand_out=0x40, instr_pc=0x00.
REQ-033 mem[0]=0x0C (opcode 0x03, one-byte) -> instr_valid after 2 cycles with operand_out=0x00; the next fetch_addr SHALL be 0x01.
REQ-034 instr_ready held 0 for 5 cycles in VALID -> outputs stable, fetch_rd_en=0 throughout; release -> next fetch at the following PC.
REQ-035 branch_en=1 with branch_target=0x80 during LATCH_OP of a two-byte instruction -> no instr_valid for it; next fetch_addr=0x80.
REQ-036 Opcode byte at 0xFF, mem[0x00]=0x11 -> operand_out=0x11 and the next fetch_addr=0x01.
REQ-037 mem[pc]=0xFC (HALT) -> halted=1 and no further fetch_rd_en; rst_n pulse -> IDLE with all outputs 0.
